// File: rtl/ethernet_st_packet_arbiter.sv
// Round-robin whole-packet arbiter feeding one Avalon-ST timing-adapter FIFO.
// New packets are held off while the FIFO is above START_THRESH; mid-packet only out_ready throttles.
module ethernet_st_packet_arbiter #(
    parameter int NUM_SRC      = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int EMPTY_WIDTH  = 2,
    parameter int FILL_WIDTH   = 5,
    parameter int START_THRESH = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_SRC-1:0]                in_valid,
    output logic [NUM_SRC-1:0]                in_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     in_data,
    input  logic [NUM_SRC-1:0]                in_sop,
    input  logic [NUM_SRC-1:0]                in_eop,
    input  logic [NUM_SRC*EMPTY_WIDTH-1:0]    in_empty,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH+EMPTY_WIDTH+1:0] out_data,
    input  logic [FILL_WIDTH-1:0]             fifo_fill_level,
    output logic [NUM_SRC-1:0]                grant,
    output logic                              busy,
    output logic                              stray_drop,
    output logic                              sop_err,
    output logic [15:0]                       pkt_count
);
    // state | meaning
    // IDLE  | no owner; arbitrate SOP requests, drain stray non-SOP beats
    // XFER  | granted source passes straight through to the FIFO until its EOP
    localparam int          PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [31:0] THRESH = 32'(START_THRESH);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 busy_q, busy_d;
    logic                 first_q, first_d;
    logic                 stray_drop_q, stray_drop_d;
    logic                 sop_err_q, sop_err_d;
    logic [15:0]          pkt_count_q, pkt_count_d;

    logic [NUM_SRC-1:0]   request;
    logic [NUM_SRC-1:0]   stray_sel;
    logic                 stray_found;
    logic [NUM_SRC-1:0]   win_onehot;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    int                   idx;
    logic [NUM_SRC-1:0]   ready_raw;
    logic                 fill_ok;

    logic                   src_valid;
    logic                   src_sop;
    logic                   src_eop;
    logic [EMPTY_WIDTH-1:0] src_empty;
    logic [DATA_WIDTH-1:0]  src_data;

    assign request = in_valid & in_sop;
    assign fill_ok = (32'(fifo_fill_level) <= THRESH);

    // ptr_q always holds the current owner while in XFER
    assign src_valid = in_valid[ptr_q];
    assign src_sop   = in_sop[ptr_q];
    assign src_eop   = in_eop[ptr_q];
    assign src_empty = in_empty[ptr_q*EMPTY_WIDTH +: EMPTY_WIDTH];
    assign src_data  = in_data[ptr_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        win_onehot = '0;
        win_idx    = ptr_q;
        win_found  = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(ptr_q) + k) % NUM_SRC;
            if (!win_found && request[idx]) begin
                win_found       = 1'b1;
                win_idx         = PTR_W'(idx);
                win_onehot[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        stray_sel   = '0;
        stray_found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!stray_found && in_valid[i] && !in_sop[i]) begin
                stray_found  = 1'b1;
                stray_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        busy_d       = busy_q;
        first_d      = first_q;
        stray_drop_d = 1'b0;
        sop_err_d    = 1'b0;
        pkt_count_d  = pkt_count_q;
        ready_raw    = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        case (state_q)
            IDLE: begin
                ready_raw    = stray_sel;
                stray_drop_d = stray_found;
                if (win_found && fill_ok) begin
                    state_d = XFER;
                    grant_d = win_onehot;
                    ptr_d   = win_idx;
                    busy_d  = 1'b1;
                    first_d = 1'b1;
                end
            end
            XFER: begin
                out_valid = src_valid;
                out_data  = {src_sop, src_eop, src_empty, src_data};
                ready_raw = grant_q & {NUM_SRC{out_ready}};
                if (src_valid && out_ready) begin
                    first_d   = 1'b0;
                    sop_err_d = src_sop & ~first_q;
                    if (src_eop) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        busy_d      = 1'b0;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Nothing may be accepted while reset is held, even a stray drain
    assign in_ready = ready_raw & {NUM_SRC{reset_n}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            ptr_q        <= PTR_W'(NUM_SRC - 1);
            busy_q       <= 1'b0;
            first_q      <= 1'b0;
            stray_drop_q <= 1'b0;
            sop_err_q    <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            first_q      <= first_d;
            stray_drop_q <= stray_drop_d;
            sop_err_q    <= sop_err_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign stray_drop = stray_drop_q;
    assign sop_err    = sop_err_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_ethernet_st_packet_arbiter.sv
// Bench for ethernet_st_packet_arbiter: per-source packet queues drive the DUT, a
// packet-level model is compared every cycle, and directed scenarios pin exact values.
module tb_ethernet_st_packet_arbiter;
    localparam int NS = 2;
    localparam int DW = 32;
    localparam int EW = 2;
    localparam int FW = 5;
    localparam int TH = 8;
    localparam int OW = DW + EW + 2;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } beat_t;

    logic             clk;
    logic             reset_n;
    logic [NS-1:0]    in_valid;
    logic [NS-1:0]    in_ready;
    logic [NS*DW-1:0] in_data;
    logic [NS-1:0]    in_sop;
    logic [NS-1:0]    in_eop;
    logic [NS*EW-1:0] in_empty;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;
    logic [FW-1:0]    fifo_fill_level;
    logic [NS-1:0]    grant;
    logic             busy;
    logic             stray_drop;
    logic             sop_err;
    logic [15:0]      pkt_count;

    ethernet_st_packet_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .FILL_WIDTH(FW), .START_THRESH(TH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_fill_level(fifo_fill_level), .grant(grant), .busy(busy),
        .stray_drop(stray_drop), .sop_err(sop_err), .pkt_count(pkt_count)
    );

    int checks = 0;
    int errors = 0;

    beat_t         src_q [NS][$];
    logic [NS-1:0] acc;
    beat_t         drv_b;

    logic [OW-1:0] xfer_log [$];
    int            xfer_cyc [$];
    logic [NS-1:0] grant_log [$];
    logic [NS-1:0] prev_grant;
    int            soperr_pulses;
    int            cyc;

    int            m_owner, m_rr, m_cnt, o, stray_src, w;
    bit            m_first, m_stray, m_soperr, picked;
    logic [NS-1:0] e_grant, e_ready;
    logic [OW-1:0] e_data;
    logic          e_valid;
    logic [OW-1:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int sum = 0;
        for (int s = 0; s < NS; s++) sum += src_q[s].size();
        return sum;
    endfunction

    task automatic push_pkt(input int s, input int n, input logic [DW-1:0] base, input logic [EW-1:0] emp);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            b.empty = (i == n - 1) ? emp : '0;
            b.data  = base + DW'(i);
            src_q[s].push_back(b);
        end
    endtask

    task automatic flush();
        for (int s = 0; s < NS; s++) src_q[s].delete();
        acc = '0;
    endtask

    task automatic clear_logs();
        xfer_log.delete();
        xfer_cyc.delete();
        grant_log.delete();
        soperr_pulses = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        out_ready = 1'b1;
        fifo_fill_level = '0;
        flush();
        tick(2);
        reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_drain(input string nm);
        int budget = 300;
        while (budget > 0 && (pending() != 0 || busy !== 1'b0)) begin
            tick(1);
            budget--;
        end
        chk({nm, "_drained"}, 64'(budget > 0), 64'd1);
    endtask

    // Source drivers: hold the head beat until the DUT accepts it
    initial begin
        acc = '0;
        forever begin
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #2;
            for (int s = 0; s < NS; s++) begin
                if (acc[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
                if (src_q[s].size() > 0) begin
                    drv_b = src_q[s][0];
                    in_valid[s]           = 1'b1;
                    in_sop[s]             = drv_b.sop;
                    in_eop[s]             = drv_b.eop;
                    in_empty[s*EW +: EW]  = drv_b.empty;
                    in_data[s*DW +: DW]   = drv_b.data;
                end else begin
                    in_valid[s]           = 1'b0;
                    in_sop[s]             = 1'b0;
                    in_eop[s]             = 1'b0;
                    in_empty[s*EW +: EW]  = '0;
                    in_data[s*DW +: DW]   = '0;
                end
            end
            acc = '0;
        end
    end

    // Packet-level model: who owns the FIFO, how many packets finished, which pulses are due
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            chk("rst_grant", 64'(grant), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_stray_drop", 64'(stray_drop), 64'd0);
            chk("rst_sop_err", 64'(sop_err), 64'd0);
            chk("rst_pkt_count", 64'(pkt_count), 64'd0);
            m_owner = -1; m_rr = NS - 1; m_cnt = 0;
            m_first = 0; m_stray = 0; m_soperr = 0;
            prev_grant = '0;
        end else begin
            o = (m_owner < 0) ? 0 : m_owner;
            stray_src = -1;
            for (int s = 0; s < NS; s++)
                if (stray_src < 0 && in_valid[s] && !in_sop[s]) stray_src = s;
            e_grant = (m_owner < 0) ? '0 : (NS'(1) << m_owner);
            e_valid = (m_owner >= 0) && in_valid[o];
            e_data  = (m_owner < 0) ? '0 :
                      {in_sop[o], in_eop[o], in_empty[o*EW +: EW], in_data[o*DW +: DW]};
            if (m_owner >= 0) e_ready = out_ready ? e_grant : '0;
            else              e_ready = (stray_src >= 0) ? (NS'(1) << stray_src) : '0;

            chk("grant", 64'(grant), 64'(e_grant));
            chk("busy", 64'(busy), 64'(m_owner >= 0));
            chk("out_valid", 64'(out_valid), 64'(e_valid));
            chk("out_data", 64'(out_data), 64'(e_data));
            chk("in_ready", 64'(in_ready), 64'(e_ready));
            chk("stray_drop", 64'(stray_drop), 64'(m_stray));
            chk("sop_err", 64'(sop_err), 64'(m_soperr));
            chk("pkt_count", 64'(pkt_count), 64'(m_cnt));

            if (out_valid && out_ready) begin
                xfer_log.push_back(out_data);
                xfer_cyc.push_back(cyc);
            end
            if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
            prev_grant = grant;
            if (sop_err) soperr_pulses++;

            m_stray  = (m_owner < 0) && (stray_src >= 0);
            m_soperr = 0;
            if (m_owner >= 0) begin
                if (in_valid[o] && out_ready) begin
                    m_soperr = !m_first && in_sop[o];
                    m_first  = 0;
                    if (in_eop[o]) begin
                        m_cnt   = (m_cnt + 1) % 65536;
                        m_owner = -1;
                    end
                end
            end else if (int'(fifo_fill_level) <= TH) begin
                picked = 0;
                for (int k = 1; k <= NS; k++) begin
                    w = (m_rr + k) % NS;
                    if (!picked && in_valid[w] && in_sop[w]) begin
                        picked = 1; m_owner = w; m_rr = w; m_first = 1;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        out_ready = 1'b1;
        fifo_fill_level = '0;
        in_valid = '0; in_data = '0; in_sop = '0; in_eop = '0; in_empty = '0;
        cyc = 0; soperr_pulses = 0; prev_grant = '0;
        m_owner = -1; m_rr = NS - 1; m_cnt = 0;
        tick(3);
        reset_n = 1'b1;
        clear_logs();

        // 1: single 3-beat packet from source 0
        push_pkt(0, 3, 32'hA000_0001, 2'd2);
        wait_drain("t1");
        chk("t1_beats", 64'(xfer_log.size()), 64'd3);
        if (xfer_log.size() == 3) begin
            chk("t1_beat0", 64'(xfer_log[0]), 64'h8_A000_0001);
            chk("t1_beat1", 64'(xfer_log[1]), 64'h0_A000_0002);
            chk("t1_beat2", 64'(xfer_log[2]), 64'h6_A000_0003);
        end
        if (grant_log.size() > 0) chk("t1_grant", 64'(grant_log[0]), 64'd1);
        else chk("t1_grant_seen", 64'd0, 64'd1);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);

        // 2: both sources back to back, 2-beat packets
        do_reset();
        push_pkt(0, 2, 32'hB000_0000, 2'd0);
        push_pkt(1, 2, 32'hB100_0000, 2'd1);
        push_pkt(0, 2, 32'hB000_0010, 2'd2);
        push_pkt(1, 2, 32'hB100_0010, 2'd3);
        wait_drain("t2");
        chk("t2_grants", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            chk("t2_grant0", 64'(grant_log[0]), 64'd1);
            chk("t2_grant1", 64'(grant_log[1]), 64'd2);
            chk("t2_grant2", 64'(grant_log[2]), 64'd1);
            chk("t2_grant3", 64'(grant_log[3]), 64'd2);
        end
        chk("t2_beats", 64'(xfer_cyc.size()), 64'd8);
        if (xfer_cyc.size() == 8)
            for (int i = 1; i < 7; i += 2)
                chk("t2_eop_gap", 64'(xfer_cyc[i+1] - xfer_cyc[i]), 64'd2);
        chk("t2_pkt_count", 64'(pkt_count), 64'd4);

        // 3: fill level above threshold holds off the grant
        do_reset();
        fifo_fill_level = 5'd9;
        push_pkt(1, 3, 32'hC100_0000, 2'd0);
        tick(4);
        @(negedge clk);
        chk("t3_blocked_grant", 64'(grant), 64'd0);
        chk("t3_blocked_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        fifo_fill_level = 5'd8;
        @(posedge clk);
        @(negedge clk);
        chk("t3_grant_at_thresh", 64'(grant), 64'd2);
        @(posedge clk); #1;
        fifo_fill_level = 5'd31;
        wait_drain("t3");
        chk("t3_beats", 64'(xfer_log.size()), 64'd3);
        chk("t3_pkt_count", 64'(pkt_count), 64'd1);

        // 4: backpressure in the middle of a 4-beat packet
        do_reset();
        push_pkt(0, 4, 32'hD000_0001, 2'd1);
        for (int b = 0; b < 50 && xfer_log.size() < 2; b++) tick(1);
        out_ready = 1'b0;
        held = {1'b0, 1'b0, 2'd0, 32'hD000_0001 + 32'(xfer_log.size())};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_ready", 64'(in_ready), 64'd0);
            chk("t4_hold_data", 64'(out_data), 64'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("t4");
        chk("t4_beats", 64'(xfer_log.size()), 64'd4);
        if (xfer_log.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("t4_order", 64'(xfer_log[i]),
                    64'({(i == 0), (i == 3), ((i == 3) ? 2'd1 : 2'd0), 32'(32'hD000_0001 + 32'(i))}));

        // 5: stray non-SOP beat while idle is drained
        do_reset();
        src_q[1].push_back('{sop: 1'b0, eop: 1'b0, empty: 2'd0, data: 32'hE100_0000});
        @(negedge clk);
        chk("t5_drain_ready", 64'(in_ready), 64'd2);
        chk("t5_drain_valid", 64'(out_valid), 64'd0);
        chk("t5_no_pulse_yet", 64'(stray_drop), 64'd0);
        @(negedge clk);
        chk("t5_stray_pulse", 64'(stray_drop), 64'd1);
        chk("t5_ready_after", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("t5_pulse_end", 64'(stray_drop), 64'd0);
        chk("t5_no_xfer", 64'(xfer_log.size()), 64'd0);

        // 6: reset on the second beat aborts at once; source 0 wins afterwards
        do_reset();
        push_pkt(0, 4, 32'hF000_0001, 2'd0);
        for (int b = 0; b < 50 && xfer_log.size() < 2; b++) begin
            @(negedge clk); #1;
        end
        reset_n = 1'b0;
        flush();
        #1;
        chk("t6_abort_valid", 64'(out_valid), 64'd0);
        chk("t6_abort_grant", 64'(grant), 64'd0);
        chk("t6_abort_busy", 64'(busy), 64'd0);
        chk("t6_abort_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        push_pkt(1, 2, 32'hF100_0000, 2'd0);
        push_pkt(0, 2, 32'hF000_0100, 2'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_logs();
        wait_drain("t6");
        if (grant_log.size() == 2) begin
            chk("t6_first_grant", 64'(grant_log[0]), 64'd1);
            chk("t6_second_grant", 64'(grant_log[1]), 64'd2);
        end else chk("t6_grants", 64'(grant_log.size()), 64'd2);
        chk("t6_pkt_count", 64'(pkt_count), 64'd2);

        // 7: SOP inside a packet, then a single-beat packet
        do_reset();
        push_pkt(0, 3, 32'h1000_0000, 2'd0);
        src_q[0][1].sop = 1'b1;
        push_pkt(0, 1, 32'h2000_0000, 2'd3);
        wait_drain("t7");
        chk("t7_sop_err_pulses", 64'(soperr_pulses), 64'd1);
        chk("t7_beats", 64'(xfer_log.size()), 64'd4);
        if (xfer_log.size() == 4) chk("t7_single", 64'(xfer_log[3]), 64'hF_2000_0000);
        chk("t7_pkt_count", 64'(pkt_count), 64'd2);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
